// File: rtl/pmod_shift_out.sv
// MSB-first serializer for a 74HC595-style shift register: serial clock, serial data, latch.
// Define PMOD_SHIFT_OUT_DOUBLE_BUF_EN to add a one-word holding buffer for gapless frames.
module pmod_shift_out #(
    parameter int width_p   = 8,
    parameter int clk_div_p = 6
) (
    input  logic               clk_i,
    input  logic               reset_n_async_i,
    input  logic               clear_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               sclk_o,
    output logic               sdo_o,
    output logic               latch_o,
    output logic               busy_o
);

    localparam int div_w_lp = $clog2(clk_div_p + 1);
    localparam int cnt_w_lp = $clog2(width_p + 1);
    localparam logic [div_w_lp-1:0] div_last_lp = div_w_lp'(clk_div_p - 1);
    localparam logic [cnt_w_lp-1:0] bit_last_lp = cnt_w_lp'(width_p - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [div_w_lp-1:0] div_q, div_d;
    logic [cnt_w_lp-1:0] bit_q, bit_d;
    logic [width_p-1:0]  shreg_q, shreg_d;
    logic [width_p-1:0]  shifted;
    logic                sclk_q, sclk_d;
    logic                sdo_q, sdo_d;
    logic                latch_q, latch_d;
    logic                busy_q, busy_d;
    logic                half_done;
    logic                accept;

    // Handshake: a word transfers on a rising clk_i edge where valid_i && ready_o && !clear_i;
    // ready_o never depends on valid_i, and data_i is ignored whenever no transfer happens.
`ifdef PMOD_SHIFT_OUT_DOUBLE_BUF_EN
    logic               buf_full_q, buf_full_d;
    logic [width_p-1:0] buf_q, buf_d;

    assign ready_o = !buf_full_q;
`else
    assign ready_o = (state_q == IDLE);
`endif

    assign accept    = valid_i && ready_o && !clear_i;
    assign half_done = (div_q == div_last_lp);
    assign shifted   = shreg_q << 1;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        sdo_d   = sdo_q;
        latch_d = latch_q;
        busy_d  = busy_q;
`ifdef PMOD_SHIFT_OUT_DOUBLE_BUF_EN
        buf_full_d = buf_full_q;
        buf_d      = buf_q;
`endif
        if (clear_i) begin
            state_d = IDLE;
            div_d   = '0;
            bit_d   = '0;
            shreg_d = '0;
            sclk_d  = 1'b0;
            sdo_d   = 1'b0;
            latch_d = 1'b0;
            busy_d  = 1'b0;
`ifdef PMOD_SHIFT_OUT_DOUBLE_BUF_EN
            buf_full_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = SHIFT;
                        shreg_d = data_i;
                        sdo_d   = data_i[width_p-1];
                        div_d   = '0;
                        bit_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
                SHIFT: begin
                    if (!half_done) begin
                        div_d = div_q + div_w_lp'(1);
                    end else begin
                        div_d = '0;
                        if (!sclk_q) begin
                            sclk_d = 1'b1;
                        end else begin
                            // Falling edge: the receiver has already sampled on the rise.
                            sclk_d = 1'b0;
                            if (bit_q == bit_last_lp) begin
                                state_d = LATCH;
                                sdo_d   = 1'b0;
                                latch_d = 1'b1;
                            end else begin
                                shreg_d = shifted;
                                sdo_d   = shifted[width_p-1];
                                bit_d   = bit_q + cnt_w_lp'(1);
                            end
                        end
                    end
                end
                LATCH: begin
                    if (!half_done) begin
                        div_d = div_q + div_w_lp'(1);
                    end else begin
                        div_d   = '0;
                        latch_d = 1'b0;
`ifdef PMOD_SHIFT_OUT_DOUBLE_BUF_EN
                        // A held word, or one arriving right now, starts with no idle gap.
                        if (buf_full_q) begin
                            state_d    = SHIFT;
                            shreg_d    = buf_q;
                            sdo_d      = buf_q[width_p-1];
                            bit_d      = '0;
                            buf_full_d = 1'b0;
                        end else if (accept) begin
                            state_d = SHIFT;
                            shreg_d = data_i;
                            sdo_d   = data_i[width_p-1];
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
`else
                        state_d = IDLE;
                        busy_d  = 1'b0;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
`ifdef PMOD_SHIFT_OUT_DOUBLE_BUF_EN
            if (accept && (state_q != IDLE) &&
                !((state_q == LATCH) && half_done && !buf_full_q)) begin
                buf_full_d = 1'b1;
                buf_d      = data_i;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_async_i) begin
        if (!reset_n_async_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
        end
    end

`ifdef PMOD_SHIFT_OUT_DOUBLE_BUF_EN
    always_ff @(posedge clk_i or negedge reset_n_async_i) begin
        if (!reset_n_async_i) begin
            buf_full_q <= 1'b0;
            buf_q      <= '0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_q      <= buf_d;
        end
    end
`endif

    assign sclk_o  = sclk_q;
    assign sdo_o   = sdo_q;
    assign latch_o = latch_q;
    assign busy_o  = busy_q;

endmodule
